// File: rtl/uart_regbus_bridge.sv
// UART (8N1) to register-bank bridge: decodes single/block read/write commands, drives a one-strobe
// register bus, and returns read data through a byte FIFO feeding the serial transmitter.
module uart_regbus_bridge #(
    parameter int unsigned CLK_FREQ     = 27000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned TXF_DEPTH    = 16,
    parameter int unsigned RD_LATENCY   = 1,
    parameter int unsigned TIMEOUT_BITS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              uart_tx,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_write_to_reg,
    input  logic [DATA_W-1:0] data_read_from_reg,
    output logic              reg_en,
    output logic              write_en,
    output logic              busy,
    output logic [7:0]        frame_err_cnt,
    output logic              timeout_pulse
);
    localparam int unsigned BIT_TIMER = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT  = BIT_TIMER / 2;
    localparam int unsigned AB        = ADDR_W / 8;
    localparam int unsigned DB        = DATA_W / 8;
    localparam int unsigned BT_W      = $clog2(BIT_TIMER + 1);
    localparam int unsigned TO_CLKS   = TIMEOUT_BITS * BIT_TIMER;
    localparam int unsigned TO_W      = $clog2(TO_CLKS + 1);
    localparam int unsigned PTR_W     = $clog2(TXF_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned LAT_W     = 3;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_LEN, P_WDATA, P_RD_ISSUE, P_RD_WAIT, P_RD_PUSH} p_state_t;

    rx_state_t         rx_state;
    logic [1:0]        rx_sync;
    logic [BT_W-1:0]   rx_tmr;
    logic [2:0]        rx_bit;
    logic [7:0]        rx_sh;
    logic              rx_valid;
    logic              rx_ferr;

    logic [7:0]        fifo_mem [TXF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  fifo_free_c;
    logic              push_c;
    logic              pop_c;
    logic [7:0]        push_byte_c;

    logic              tx_active;
    logic [8:0]        tx_sh;
    logic [3:0]        tx_bit;
    logic [BT_W-1:0]   tx_tmr;
    logic              tx_end_c;

    p_state_t          p_state;
    logic              is_wr;
    logic              is_blk;
    logic [ADDR_W-1:0] cur_addr;
    logic [1:0]        byte_cnt;
    logic [8:0]        words_left;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] push_word_c;
    logic [LAT_W-1:0]  lat_cnt;
    logic [TO_W-1:0]   to_cnt;

    // Receiver: start re-checked at half bit, data and stop sampled mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync       <= 2'b11;
            rx_state      <= RX_IDLE;
            rx_tmr        <= '0;
            rx_bit        <= '0;
            rx_sh         <= '0;
            rx_valid      <= 1'b0;
            rx_ferr       <= 1'b0;
            frame_err_cnt <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], uart_rx};
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_tmr <= '0;
                    if (!rx_sync[1]) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_tmr == BT_W'(HALF_BIT - 1)) begin
                        rx_tmr   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tmr <= rx_tmr + BT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_tmr == BT_W'(BIT_TIMER - 1)) begin
                        rx_tmr <= '0;
                        rx_sh  <= {rx_sync[1], rx_sh[7:1]};
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_tmr <= rx_tmr + BT_W'(1);
                    end
                end
                default: begin
                    if (rx_tmr == BT_W'(BIT_TIMER - 1)) begin
                        rx_tmr   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync[1]) begin
                            rx_valid <= 1'b1;
                        end else begin
                            rx_ferr <= 1'b1;
                            if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
                        end
                    end else begin
                        rx_tmr <= rx_tmr + BT_W'(1);
                    end
                end
            endcase
        end
    end

    // TX byte FIFO; free-space check in RD_ISSUE guarantees pushes never overflow.
    assign fifo_free_c = CNT_W'(TXF_DEPTH) - fifo_cnt;
    assign tx_end_c    = tx_active && (tx_bit == 4'd9) && (tx_tmr == BT_W'(BIT_TIMER - 1));
    assign pop_c       = (!tx_active || tx_end_c) && (fifo_cnt != '0);

    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr] <= push_byte_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Transmitter: a new byte is loaded at the end of the stop bit, so no idle gap between bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_tx   <= 1'b1;
            tx_active <= 1'b0;
            tx_sh     <= '1;
            tx_bit    <= '0;
            tx_tmr    <= '0;
        end else if (pop_c) begin
            uart_tx   <= 1'b0;
            tx_sh     <= {1'b1, fifo_mem[rd_ptr]};
            tx_bit    <= '0;
            tx_tmr    <= '0;
            tx_active <= 1'b1;
        end else if (tx_active) begin
            if (tx_tmr == BT_W'(BIT_TIMER - 1)) begin
                tx_tmr <= '0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                end else begin
                    uart_tx <= tx_sh[0];
                    tx_sh   <= {1'b1, tx_sh[8:1]};
                    tx_bit  <= tx_bit + 4'd1;
                end
            end else begin
                tx_tmr <= tx_tmr + BT_W'(1);
            end
        end
    end

    // First push byte comes straight from the bus; the rest from the captured word.
    assign push_c      = (p_state == P_RD_PUSH);
    assign push_word_c = (byte_cnt == 2'd0) ? data_read_from_reg : rdata;
    assign push_byte_c = push_word_c[DATA_W-1 -: 8];

    // Protocol FSM and register-bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_state           <= P_IDLE;
            is_wr             <= 1'b0;
            is_blk            <= 1'b0;
            cur_addr          <= '0;
            byte_cnt          <= '0;
            words_left        <= '0;
            wdata             <= '0;
            rdata             <= '0;
            lat_cnt           <= '0;
            to_cnt            <= '0;
            address           <= '0;
            data_write_to_reg <= '0;
            reg_en            <= 1'b0;
            write_en          <= 1'b0;
            timeout_pulse     <= 1'b0;
            busy              <= 1'b0;
        end else begin
            reg_en        <= 1'b0;
            write_en      <= 1'b0;
            timeout_pulse <= 1'b0;
            busy          <= (p_state != P_IDLE) || (fifo_cnt != '0) || tx_active;
            case (p_state)
                P_IDLE: begin
                    if (rx_valid) begin
                        byte_cnt   <= '0;
                        to_cnt     <= '0;
                        words_left <= 9'd1;
                        case (rx_sh)
                            "W", "w": begin is_wr <= 1'b1; is_blk <= 1'b0; p_state <= P_ADDR; end
                            "R", "r": begin is_wr <= 1'b0; is_blk <= 1'b0; p_state <= P_ADDR; end
                            "B":      begin is_wr <= 1'b1; is_blk <= 1'b1; p_state <= P_ADDR; end
                            "b":      begin is_wr <= 1'b0; is_blk <= 1'b1; p_state <= P_ADDR; end
                            default:  ;
                        endcase
                    end
                end
                P_ADDR, P_LEN, P_WDATA: begin
                    if (rx_ferr) begin
                        p_state <= P_IDLE;
                    end else if (rx_valid) begin
                        to_cnt <= '0;
                        if (p_state == P_ADDR) begin
                            cur_addr <= ADDR_W'({cur_addr, rx_sh});
                            if (byte_cnt == 2'(AB - 1)) begin
                                byte_cnt <= '0;
                                p_state  <= is_blk ? P_LEN : (is_wr ? P_WDATA : P_RD_ISSUE);
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end else if (p_state == P_LEN) begin
                            words_left <= (rx_sh == 8'd0) ? 9'd256 : {1'b0, rx_sh};
                            p_state    <= is_wr ? P_WDATA : P_RD_ISSUE;
                        end else begin
                            wdata <= DATA_W'({wdata, rx_sh});
                            if (byte_cnt == 2'(DB - 1)) begin
                                reg_en            <= 1'b1;
                                write_en          <= 1'b1;
                                address           <= cur_addr;
                                data_write_to_reg <= DATA_W'({wdata, rx_sh});
                                cur_addr          <= cur_addr + ADDR_W'(1);
                                byte_cnt          <= '0;
                                words_left        <= words_left - 9'd1;
                                if (words_left == 9'd1) p_state <= P_IDLE;
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end
                    end else if (to_cnt == TO_W'(TO_CLKS - 1)) begin
                        p_state       <= P_IDLE;
                        timeout_pulse <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                P_RD_ISSUE: begin
                    if (fifo_free_c >= CNT_W'(DB)) begin
                        reg_en  <= 1'b1;
                        address <= cur_addr;
                        lat_cnt <= '0;
                        p_state <= P_RD_WAIT;
                    end
                end
                P_RD_WAIT: begin
                    if (lat_cnt == LAT_W'(RD_LATENCY - 1)) begin
                        byte_cnt <= '0;
                        p_state  <= P_RD_PUSH;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                default: begin
                    rdata <= push_word_c << 8;
                    if (byte_cnt == 2'(DB - 1)) begin
                        byte_cnt   <= '0;
                        cur_addr   <= cur_addr + ADDR_W'(1);
                        words_left <= words_left - 9'd1;
                        p_state    <= (words_left == 9'd1) ? P_IDLE : P_RD_ISSUE;
                    end else begin
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_regbus_bridge.sv
// Bench for uart_regbus_bridge: serial commands in, register-bank model with read latency,
// serial decoder on uart_tx, all compared against a command-level reference model.
module tb_uart_regbus_bridge;
    localparam int unsigned CLK_FREQ     = 800;
    localparam int unsigned BAUD_RATE    = 100;
    localparam int unsigned BIT          = CLK_FREQ / BAUD_RATE;
    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned TXF_DEPTH    = 4;
    localparam int unsigned RD_LATENCY   = 3;
    localparam int unsigned TIMEOUT_BITS = 64;
    localparam int unsigned TO_CLKS      = TIMEOUT_BITS * BIT;
    localparam int          BUDGET       = 60000;

    logic              clk = 1'b0;
    logic              reset;
    logic              uart_rx;
    logic              uart_tx;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_write_to_reg;
    logic [DATA_W-1:0] data_read_from_reg;
    logic              reg_en;
    logic              write_en;
    logic              busy;
    logic [7:0]        frame_err_cnt;
    logic              timeout_pulse;

    always #5 clk = ~clk;

    uart_regbus_bridge #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .TXF_DEPTH(TXF_DEPTH), .RD_LATENCY(RD_LATENCY), .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx), .address(address),
        .data_write_to_reg(data_write_to_reg), .data_read_from_reg(data_read_from_reg),
        .reg_en(reg_en), .write_en(write_en), .busy(busy), .frame_err_cnt(frame_err_cnt),
        .timeout_pulse(timeout_pulse)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] env_mem [256];
    logic [15:0] ref_mem [256];
    logic [23:0] wlog [$];
    logic [23:0] exp_w [$];
    logic [7:0]  txq [$];
    logic [7:0]  exp_tx [$];
    logic [15:0] fixed_q [$];
    int wlog_base = 0;
    int tx_base = 0;
    int rd_strobes = 0;
    int bad_we = 0;
    int to_pulses = 0;
    int tx_ferr = 0;
    logic        rd_v [1:RD_LATENCY];
    logic [15:0] rd_d [1:RD_LATENCY];

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 257 + 16'h1234);
    endfunction

    // Register bank with RD_LATENCY read pipeline; junk outside the valid cycle.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
            for (int j = 1; j <= RD_LATENCY; j++) rd_v[j] <= 1'b0;
        end else begin
            if (reg_en && write_en) begin
                env_mem[address] <= data_write_to_reg;
                wlog.push_back({address, data_write_to_reg});
            end
            if (reg_en && !write_en) rd_strobes <= rd_strobes + 1;
            if (write_en && !reg_en) bad_we <= bad_we + 1;
            if (timeout_pulse) to_pulses <= to_pulses + 1;
            rd_v[1] <= reg_en && !write_en;
            rd_d[1] <= env_mem[address];
            for (int j = 2; j <= RD_LATENCY; j++) begin
                rd_v[j] <= rd_v[j-1];
                rd_d[j] <= rd_d[j-1];
            end
        end
    end
    assign data_read_from_reg = rd_v[RD_LATENCY] ? rd_d[RD_LATENCY] : 16'hDEAD;

    // Serial decoder on uart_tx, sampling mid-bit on falling clock edges.
    always begin : tx_mon
        logic [7:0] b;
        @(negedge uart_tx);
        if (!reset) begin
            repeat (BIT / 2) @(negedge clk);
            if (uart_tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (BIT) @(negedge clk);
                if (uart_tx) txq.push_back(b);
                else tx_ferr++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (BIT) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
        repeat ($urandom_range(0, 2) * BIT) @(negedge clk);
    endtask

    // Reference model: a command expands into expected bus writes and returned bytes.
    task automatic issue(input logic [7:0] c, input logic [7:0] base, input logic [7:0] len);
        bit wr, blk;
        int n;
        logic [15:0] w, v;
        logic [7:0] a;
        wr  = (c == "W" || c == "w" || c == "B");
        blk = (c == "B" || c == "b");
        n   = !blk ? 1 : ((len == 8'd0) ? 256 : int'(len));
        send(c);
        send(base);
        if (blk) send(len);
        for (int k = 0; k < n; k++) begin
            a = 8'(int'(base) + k);
            if (wr) begin
                if (fixed_q.size() != 0) w = fixed_q.pop_front();
                else w = 16'($urandom);
                send(w[15:8]);
                send(w[7:0]);
                ref_mem[a] = w;
                exp_w.push_back({a, w});
            end else begin
                v = ref_mem[a];
                exp_tx.push_back(v[15:8]);
                exp_tx.push_back(v[7:0]);
            end
        end
    endtask

    task automatic run_and_check(input string tag);
        int n;
        bit seen;
        logic busy_seen;
        n = 0;
        seen = 1'b0;
        busy_seen = 1'b1;
        while ((wlog.size() < wlog_base + exp_w.size() || txq.size() < tx_base + exp_tx.size()
                || busy !== 1'b0) && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (!seen && exp_tx.size() != 0 && txq.size() >= tx_base + exp_tx.size()) begin
                seen = 1'b1;
                busy_seen = busy;
            end
        end
        repeat (20 * BIT) @(negedge clk);
        chk({tag, "_done"}, 32'(n < BUDGET), 32'd1);
        if (exp_tx.size() != 0) chk({tag, "_busy_last_stop"}, 32'(busy_seen), 32'd1);
        chk({tag, "_nwrites"}, 32'(wlog.size() - wlog_base), 32'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && wlog_base + k < wlog.size(); k++)
            chk({tag, "_write"}, 32'(wlog[wlog_base + k]), 32'(exp_w[k]));
        chk({tag, "_ntx"}, 32'(txq.size() - tx_base), 32'(exp_tx.size()));
        for (int k = 0; k < exp_tx.size() && tx_base + k < txq.size(); k++)
            chk({tag, "_txbyte"}, 32'(txq[tx_base + k]), 32'(exp_tx[k]));
        wlog_base = wlog.size();
        tx_base   = txq.size();
        exp_w.delete();
        exp_tx.delete();
    endtask

    initial begin
        int rs, tb0, n;
        logic [7:0] c;
        uart_rx = 1'b1;
        reset   = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (3) @(negedge clk);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_wdata", 32'(data_write_to_reg), 32'd0);
        chk("rst_reg_en", 32'(reg_en), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr_cnt", 32'(frame_err_cnt), 32'd0);
        chk("rst_timeout", 32'(timeout_pulse), 32'd0);
        reset = 1'b0;
        repeat (4 * BIT) @(negedge clk);

        // Single write and read back through the latency pipeline.
        fixed_q.push_back(16'hABCD);
        issue("W", 8'h12, 8'd0);
        run_and_check("w_12");
        fixed_q.push_back(16'hBEEF);
        issue("w", 8'h05, 8'd0);
        run_and_check("w_05");
        rs = rd_strobes;
        issue("R", 8'h05, 8'd0);
        run_and_check("r_05");
        chk("r_05_strobes", 32'(rd_strobes - rs), 32'd1);
        chk("r_05_msb", 32'(txq[tx_base - 2]), 32'hBE);
        chk("r_05_lsb", 32'(txq[tx_base - 1]), 32'hEF);

        // Block write wrapping the address space.
        fixed_q.push_back(16'h0011);
        fixed_q.push_back(16'h0022);
        fixed_q.push_back(16'h0033);
        issue("B", 8'hFE, 8'd3);
        run_and_check("blk_wrap");

        // Random commands.
        for (int it = 0; it < 8; it++) begin
            case ($urandom_range(0, 5))
                0: c = "W";
                1: c = "w";
                2: c = "R";
                3: c = "r";
                4: c = "B";
                default: c = "b";
            endcase
            issue(c, 8'($urandom), 8'($urandom_range(1, 4)));
            run_and_check("rand");
        end

        // len=0 block read: 256 words through a 4-byte FIFO.
        rs = rd_strobes;
        issue("b", 8'h00, 8'd0);
        run_and_check("blk_rd_256");
        chk("blk_rd_256_strobes", 32'(rd_strobes - rs), 32'd256);

        chk("no_timeouts_yet", 32'(to_pulses), 32'd0);
        chk("we_only_with_en", 32'(bad_we), 32'd0);
        chk("tx_stop_bits", 32'(tx_ferr), 32'd0);
        chk("no_frame_errs_yet", 32'(frame_err_cnt), 32'd0);

        // Frame error mid 'W' aborts the command.
        send_byte("W", 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (30 * BIT) @(negedge clk);
        chk("ferr_cnt", 32'(frame_err_cnt), 32'd1);
        fixed_q.push_back(16'h1234);
        issue("W", 8'h21, 8'd0);
        run_and_check("ferr_next");
        chk("ferr_no_timeout", 32'(to_pulses), 32'd0);

        // Inter-byte timeout after a partial command.
        tb0 = to_pulses;
        send_byte("W", 1'b1);
        send_byte(8'h10, 1'b1);
        n = 0;
        while (timeout_pulse !== 1'b1 && n < 2 * TO_CLKS) begin
            @(negedge clk);
            n++;
        end
        chk("to_seen", 32'(n < 2 * TO_CLKS), 32'd1);
        chk("to_delay_window", 32'(n >= TO_CLKS - BIT && n <= TO_CLKS + BIT), 32'd1);
        repeat (4) @(negedge clk);
        chk("to_one_pulse", 32'(to_pulses - tb0), 32'd1);
        chk("to_no_write", 32'(wlog.size()), 32'(wlog_base));
        chk("to_idle", 32'(busy), 32'd0);

        // Reset in the middle of a transmitted byte.
        send_byte("R", 1'b1);
        send_byte(8'h12, 1'b1);
        n = 0;
        while (uart_tx !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("midtx_started", 32'(n < 4000), 32'd1);
        repeat (3 * BIT) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midtx_rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("midtx_rst_busy", 32'(busy), 32'd0);
        chk("midtx_rst_ferr", 32'(frame_err_cnt), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        chk("post_rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
